fifo_to_axis_video: RTL and testbench

//   Reader for the src_rdy/dst_rdy FIFO interface: drains words from a fifo_short

---
 rtl/fifo_to_axis_video.sv | 145 ++++++++++++++
 tb/tb_fifo_to_axis_video.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_to_axis_video.sv
// Drains a src_rdy/dst_rdy FIFO into an AXI4-Stream video master, tagging tuser/tlast from pixel/line counters.
// Latency: a word accepted from the FIFO at cycle N is presented on m_axis at N+1.
// Backpressure: one-entry skid buffer absorbs the in-flight word; dst_rdy_o drops while the skid is occupied.
module fifo_to_axis_video #(
    parameter int WIDTH       = 32,
    parameter int LINE_PIXELS = 640,
    parameter int FRAME_LINES = 480,
    parameter int CW          = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_i,
    input  logic             src_rdy_i,
    output logic             dst_rdy_o,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tuser,
    output logic             m_axis_tlast,
    output logic [CW-1:0]    pix_cnt,
    output logic [CW-1:0]    line_cnt,
    output logic             frame_done
);

    localparam logic [CW-1:0] PIX_LAST  = CW'(LINE_PIXELS - 1);
    localparam logic [CW-1:0] LINE_LAST = CW'(FRAME_LINES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;

    // Skid entry: holds the word accepted while the output register is stalled.
    logic             r_skid_vld;
    logic [WIDTH-1:0] r_skid_dat;
    logic             r_skid_user;
    logic             r_skid_last;
    logic             r_skid_eof;

    // End-of-frame marker travelling with the beat in the output register.
    logic             r_out_eof;

    logic             w_flush;
    logic             w_accept;
    logic             w_drain;
    logic             w_out_load;
    logic             w_tuser;
    logic             w_tlast;
    logic             w_eof;

    assign w_flush    = reset | clear;
    assign dst_rdy_o  = (r_state == S_RUN) & ~r_skid_vld;
    assign w_accept   = src_rdy_i & dst_rdy_o;
    assign w_drain    = m_axis_tvalid & m_axis_tready;
    // Output register may take a new beat when it is empty or its beat leaves this cycle.
    assign w_out_load = w_drain | ~m_axis_tvalid;

    assign w_tuser    = (pix_cnt == '0) && (line_cnt == '0);
    assign w_tlast    = (pix_cnt == PIX_LAST);
    assign w_eof      = w_tlast && (line_cnt == LINE_LAST);

    // Frame FSM and pixel/line counters; enable is only honoured at frame boundaries.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_state  <= S_IDLE;
            pix_cnt  <= '0;
            line_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_tlast) begin
                            pix_cnt <= '0;
                            if (line_cnt == LINE_LAST) begin
                                line_cnt <= '0;
                                if (!enable) begin
                                    r_state <= S_IDLE;
                                end
                            end else begin
                                line_cnt <= line_cnt + 1'b1;
                            end
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output register and skid buffer; the skid has priority so beat order is preserved.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            r_out_eof     <= 1'b0;
            r_skid_vld    <= 1'b0;
            r_skid_dat    <= '0;
            r_skid_user   <= 1'b0;
            r_skid_last   <= 1'b0;
            r_skid_eof    <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= w_drain & r_out_eof;
            if (w_out_load) begin
                if (r_skid_vld) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= r_skid_dat;
                    m_axis_tuser  <= r_skid_user;
                    m_axis_tlast  <= r_skid_last;
                    r_out_eof     <= r_skid_eof;
                    r_skid_vld    <= 1'b0;
                end else if (w_accept) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= data_i;
                    m_axis_tuser  <= w_tuser;
                    m_axis_tlast  <= w_tlast;
                    r_out_eof     <= w_eof;
                end else begin
                    m_axis_tvalid <= 1'b0;
                    r_out_eof     <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid_vld  <= 1'b1;
                r_skid_dat  <= data_i;
                r_skid_user <= w_tuser;
                r_skid_last <= w_tlast;
                r_skid_eof  <= w_eof;
            end
        end
    end

endmodule

// File: tb/tb_fifo_to_axis_video.sv
// Randomized bench for fifo_to_axis_video with a frame-level reference model and scoreboard.
// Expected beats are queued at FIFO accept time and compared when they leave on AXI.
// Occupancy (beats accepted but not yet delivered) predicts tvalid and dst_rdy_o.
module tb_fifo_to_axis_video;

    localparam int W  = 8;
    localparam int LP = 4;
    localparam int FL = 2;
    localparam int CW = 4;
    localparam int NB = LP * FL;

    logic          clk;
    logic          reset;
    logic          clear;
    logic          enable;
    logic [W-1:0]  data_i;
    logic          src_rdy_i;
    logic          dst_rdy_o;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic [CW-1:0] pix_cnt;
    logic [CW-1:0] line_cnt;
    logic          frame_done;

    fifo_to_axis_video #(
        .WIDTH(W), .LINE_PIXELS(LP), .FRAME_LINES(FL), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .enable(enable),
        .data_i(data_i), .src_rdy_i(src_rdy_i), .dst_rdy_o(dst_rdy_o),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .pix_cnt(pix_cnt), .line_cnt(line_cnt),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] d;
        logic         u;
        logic         l;
        logic         e;
    } beat_t;

    // Reference model state: position in frame, frame running, beats in flight.
    beat_t sb[$];
    int    k          = 0;
    bit    run        = 1'b0;
    int    inflight   = 0;
    bit    pend_rst   = 1'b0;
    bit    exp_fd     = 1'b0;
    bit    prev_stall = 1'b0;
    logic [W+1:0] held;

    // Monitor: check settled outputs, then advance the model for the coming edge.
    always @(negedge clk) begin : mon
        beat_t b;
        if (pend_rst) begin
            chk("rst_tvalid", m_axis_tvalid, 0);
            chk("rst_tuser",  m_axis_tuser,  0);
            chk("rst_tlast",  m_axis_tlast,  0);
            chk("rst_tdata",  m_axis_tdata,  0);
        end
        chk("frame_done", frame_done, exp_fd);
        chk("pix_cnt",  pix_cnt,  k % LP);
        chk("line_cnt", line_cnt, k / LP);
        chk("dst_rdy_o", dst_rdy_o, (run && inflight < 2) ? 1 : 0);
        chk("tvalid", m_axis_tvalid, (inflight > 0) ? 1 : 0);
        if (prev_stall) begin
            chk("hold_stable", {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast},
                {1'b1, held});
        end
        prev_stall = m_axis_tvalid & ~m_axis_tready;
        held       = {m_axis_tdata, m_axis_tuser, m_axis_tlast};

        if (reset || clear) begin
            sb.delete();
            k          = 0;
            run        = 1'b0;
            inflight   = 0;
            pend_rst   = 1'b1;
            exp_fd     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            pend_rst = 1'b0;
            exp_fd   = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    b = sb.pop_front();
                    chk("tdata", m_axis_tdata, b.d);
                    chk("tuser", m_axis_tuser, b.u);
                    chk("tlast", m_axis_tlast, b.l);
                    exp_fd = b.e;
                end
                if (inflight > 0) inflight--;
            end
            if (src_rdy_i && dst_rdy_o) begin
                b.d = data_i;
                b.u = (k == 0);
                b.l = (k % LP == LP - 1);
                b.e = (k == NB - 1);
                sb.push_back(b);
                inflight++;
                k++;
                if (k == NB) begin
                    k   = 0;
                    run = enable;
                end
            end else if (!run) begin
                run = enable;
            end
        end
    end

    // Drive one cycle of inputs; a new FIFO word appears after each accepted read.
    task automatic step(input bit s, input bit t, input bit e);
        bit fire;
        src_rdy_i     = s;
        m_axis_tready = t;
        enable        = e;
        fire          = s && dst_rdy_o;
        @(posedge clk);
        #1;
        if (fire) data_i = W'($urandom_range(0, 255));
    endtask

    initial begin
        reset         = 1'b1;
        clear         = 1'b0;
        enable        = 1'b0;
        src_rdy_i     = 1'b0;
        m_axis_tready = 1'b0;
        data_i        = 8'h00;
        repeat (3) step(0, 0, 0);
        reset = 1'b0;

        // Back-to-back frame with everything ready.
        for (int i = 0; i < 12; i++) step(1, 1, 1);

        // tready held low for 3 cycles mid-line.
        step(1, 1, 1); step(1, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 1);
        for (int i = 0; i < 10; i++) step(1, 1, 1);

        // enable dropped mid-frame, frame still completes, then re-enable.
        for (int i = 0; i < 3; i++) step(1, 1, 1);
        for (int i = 0; i < 15; i++) step(1, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 1);

        // FIFO with data every other cycle.
        for (int i = 0; i < 20; i++) step(i % 2 == 0, 1, 1);

        // Clear while output and skid are both full.
        for (int i = 0; i < 4; i++) step(1, 0, 1);
        clear = 1'b1;
        step(1, 0, 1);
        clear = 1'b0;
        for (int i = 0; i < 6; i++) step(1, 1, 1);

        // Reset under backpressure, then hold off enable.
        step(1, 0, 1);
        reset = 1'b1;
        step(1, 0, 1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 1);

        // Random traffic with occasional clear.
        for (int i = 0; i < 400; i++) begin
            clear = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 7) != 0);
        end
        clear = 1'b0;

        // Drain remaining beats within a bounded number of cycles.
        for (int i = 0; i < 50 && inflight > 0; i++) step(0, 1, 0);
        step(0, 1, 0);
        chk("drain_done", inflight, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
